// File: rtl/display_pkg.sv
// Shared types and the hex-to-7-segment decode used by the display scanner.
package display_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-high patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef enum logic {
      GUARD = 1'b0,
      ON    = 1'b1
   } scan_state_t;

   function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nibble);
      return ~SEG_LUT[nibble];
   endfunction

endpackage

// File: rtl/scan_timer.sv
// Free-running per-digit slot counter; one period is a full guard+on dwell,
// so the scan FSM only has to react to the two pulses.
module scan_timer
   import display_pkg::*;
#(
   parameter int DWELL_CYCLES = 6750,
   parameter int GUARD_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   output logic guard_done_o,
   output logic dwell_done_o
);

   localparam int CW = $clog2(DWELL_CYCLES);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: wrap at the end of each digit slot.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q == DWELL_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign guard_done_o = (cnt_q == GUARD_LAST);
   assign dwell_done_o = (cnt_q == DWELL_LAST);

endmodule

// File: rtl/display_scan.sv
// Multiplexed common-anode 7-segment driver with ghosting guard and
// frame-synchronous double buffering. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan
   import display_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int DWELL_CYCLES = 6750,
   parameter int GUARD_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [4*N_DIGITS-1:0] digits_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   input  logic [N_DIGITS-1:0]   blank_i,
   output logic [N_DIGITS-1:0]   an_o,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic                  frame_o,
   output logic                  busy_o
);

   localparam int IW = $clog2(N_DIGITS);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

   scan_state_t           state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*N_DIGITS-1:0] sh_dig_q, sh_dig_d;
   logic [N_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [N_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic                  pending_q, pending_d;
   logic [4*N_DIGITS-1:0] act_dig_q, act_dig_d;
   logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
   logic [N_DIGITS-1:0]   act_blank_q, act_blank_d;
   logic                  act_valid_q, act_valid_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic                  frame_q, frame_d;

   logic                  guard_done_s;
   logic                  dwell_done_s;
   logic                  frame_tick_s;
   logic [N_DIGITS-1:0]   cp_blank_s;
   logic [N_DIGITS-1:0]   cp_dp_s;

   scan_timer #(
      .DWELL_CYCLES (DWELL_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .guard_done_o (guard_done_s),
      .dwell_done_o (dwell_done_s)
   );

   assign frame_tick_s = (state_q == ON) && dwell_done_s && (idx_q == IDX_LAST);

   // Blank/dp masks as they will land in the active buffer on a copy.
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      logic lead_s;
      cp_blank_s = sh_blank_q;
      cp_dp_s    = sh_dp_q;
      lead_s     = 1'b1;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         if (lead_s && (sh_dig_q[4*i +: 4] == 4'h0)) begin
            cp_blank_s[i] = 1'b1;
            cp_dp_s[i]    = 1'b0;
         end else begin
            lead_s = 1'b0;
         end
      end
`else
      cp_blank_s = sh_blank_q;
      cp_dp_s    = sh_dp_q;
`endif
   end

   // Scan sequencing, shadow capture and frame-boundary copy.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sh_dig_d    = sh_dig_q;
      sh_dp_d     = sh_dp_q;
      sh_blank_d  = sh_blank_q;
      pending_d   = pending_q;
      act_dig_d   = act_dig_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      act_valid_d = act_valid_q;

      case (state_q)
         GUARD: begin
            if (guard_done_s) begin
               state_d = ON;
            end else begin
               state_d = GUARD;
            end
         end
         ON: begin
            if (dwell_done_s) begin
               state_d = GUARD;
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               state_d = ON;
            end
         end
         default: begin
            state_d = GUARD;
         end
      endcase

      // Copy uses the shadow as it stood before any coincident load.
      if (frame_tick_s && pending_q) begin
         act_dig_d   = sh_dig_q;
         act_dp_d    = cp_dp_s;
         act_blank_d = cp_blank_s;
         act_valid_d = 1'b1;
         pending_d   = 1'b0;
      end else begin
         act_valid_d = act_valid_q;
      end

      if (load_i) begin
         sh_dig_d   = digits_i;
         sh_dp_d    = dp_i;
         sh_blank_d = blank_i;
         pending_d  = 1'b1;
      end else begin
         sh_dig_d = sh_dig_q;
      end
   end

   // Registered pad drive for the current slot.
   always_comb begin
      an_d    = '1;
      seg_d   = SEG_OFF;
      dp_d    = 1'b1;
      frame_d = frame_tick_s;
      if ((state_q == ON) && act_valid_q) begin
         an_d[idx_q] = 1'b0;
         if (act_blank_q[idx_q]) begin
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
         end else begin
            seg_d = hex_to_seg_n(act_dig_q[{idx_q, 2'b00} +: 4]);
            dp_d  = ~act_dp_q[idx_q];
         end
      end else begin
         an_d = '1;
      end
   end

   // State and buffer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= GUARD;
         idx_q       <= '0;
         sh_dig_q    <= '0;
         sh_dp_q     <= '0;
         sh_blank_q  <= '1;
         pending_q   <= 1'b0;
         act_dig_q   <= '0;
         act_dp_q    <= '0;
         act_blank_q <= '1;
         act_valid_q <= 1'b0;
         an_q        <= '1;
         seg_q       <= SEG_OFF;
         dp_q        <= 1'b1;
         frame_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sh_dig_q    <= sh_dig_d;
         sh_dp_q     <= sh_dp_d;
         sh_blank_q  <= sh_blank_d;
         pending_q   <= pending_d;
         act_dig_q   <= act_dig_d;
         act_dp_q    <= act_dp_d;
         act_blank_q <= act_blank_d;
         act_valid_q <= act_valid_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
         frame_q     <= frame_d;
      end
   end

   assign an_o    = an_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;
   assign frame_o = frame_q;
   assign busy_o  = pending_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed self-checking bench for display_scan (N=4, dwell 8, guard 2).
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_display_scan;

   logic        clk;
   logic        rst;
   logic        load_i;
   logic [15:0] digits_i;
   logic [3:0]  dp_i;
   logic [3:0]  blank_i;
   logic [3:0]  an_o;
   logic [6:0]  seg_o;
   logic        dp_o;
   logic        frame_o;
   logic        busy_o;

   int n_cmp;
   int n_bad;

   display_scan #(
      .N_DIGITS     (4),
      .DWELL_CYCLES (8),
      .GUARD_CYCLES (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load_i),
      .digits_i (digits_i),
      .dp_i     (dp_i),
      .blank_i  (blank_i),
      .an_o     (an_o),
      .seg_o    (seg_o),
      .dp_o     (dp_o),
      .frame_o  (frame_o),
      .busy_o   (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((frame_o !== 1'b1) && (n < 100));
      check_val(tag, 32'(frame_o), 32'd1);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
      load_i   = 1'b1;
      digits_i = d;
      dp_i     = dp;
      blank_i  = bl;
      tick();
      load_i   = 1'b0;
   endtask

   // Starts in a frame_o cycle; walks the next 32 cycles against the expected digits.
   task automatic check_frame(input string tag, input logic [27:0] seg_e, input logic [3:0] dpn_e);
      logic [3:0] one4;
      logic [3:0] an_x;
      logic [6:0] seg_x;
      logic       dp_x;
      int         k;
      one4 = 4'b0001;
      for (int j = 1; j <= 32; j++) begin
         tick();
         if ((j >= 3) && (((j - 3) % 8) < 6)) begin
            k     = (j - 3) / 8;
            an_x  = ~(one4 << k);
            seg_x = seg_e[k*7 +: 7];
            dp_x  = dpn_e[k];
         end else begin
            an_x  = 4'hF;
            seg_x = 7'h7F;
            dp_x  = 1'b1;
         end
         check_val($sformatf("%s_an@%0d", tag, j), 32'(an_o), 32'(an_x));
         check_val($sformatf("%s_seg@%0d", tag, j), 32'(seg_o), 32'(seg_x));
         check_val($sformatf("%s_dp@%0d", tag, j), 32'(dp_o), 32'(dp_x));
      end
      check_val($sformatf("%s_frame_end", tag), 32'(frame_o), 32'd1);
   endtask

   initial begin
      int  cnt;
      logic dark_ok;
      n_cmp    = 0;
      n_bad    = 0;
      rst      = 1'b1;
      load_i   = 1'b0;
      digits_i = 16'h0000;
      dp_i     = 4'h0;
      blank_i  = 4'h0;

      repeat (3) tick();
      check_val("rst_an", 32'(an_o), 32'hF);
      check_val("rst_seg", 32'(seg_o), 32'h7F);
      check_val("rst_dp", 32'(dp_o), 32'd1);
      check_val("rst_frame", 32'(frame_o), 32'd0);
      check_val("rst_busy", 32'(busy_o), 32'd0);
      rst = 1'b0;

      dark_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if ((an_o !== 4'hF) || (seg_o !== 7'h7F)) dark_ok = 1'b0;
      end
      check_val("dark_before_load", 32'(dark_ok), 32'd1);

      wait_frame("first_frame");
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while ((frame_o !== 1'b1) && (cnt < 100));
      check_val("frame_period", 32'(cnt), 32'd32);

      // Basic load, applied at the next frame boundary.
      do_load(16'h12AF, 4'b0000, 4'b0000);
      check_val("busy_after_load", 32'(busy_o), 32'd1);
      repeat (10) tick();
      check_val("busy_pending", 32'(busy_o), 32'd1);
      wait_frame("frame_12af");
      check_val("busy_cleared", 32'(busy_o), 32'd0);
      check_frame("f12af", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111);

      // Decimal point on digit 1, digit 3 force-blanked.
      do_load(16'h12AF, 4'b0010, 4'b1000);
      wait_frame("frame_dpbl");
      check_frame("fdpbl", {7'h7F, 7'h24, 7'h08, 7'h0E}, 4'b1101);

      // Two loads before the boundary: last one wins.
      do_load(16'h1111, 4'b0000, 4'b0000);
      tick();
      tick();
      do_load(16'h2222, 4'b0000, 4'b0000);
      check_val("busy_double", 32'(busy_o), 32'd1);
      wait_frame("frame_2222");
      check_frame("f2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

      // Load coincident with the copy cycle.
      do_load(16'h3333, 4'b0000, 4'b0000);
      repeat (30) tick();
      check_val("busy_before_copy", 32'(busy_o), 32'd1);
      do_load(16'h4444, 4'b0000, 4'b0000);
      check_val("coinc_frame", 32'(frame_o), 32'd1);
      check_val("coinc_busy", 32'(busy_o), 32'd1);
      check_frame("f3333", {7'h30, 7'h30, 7'h30, 7'h30}, 4'b1111);
      check_val("coinc_busy_drop", 32'(busy_o), 32'd0);
      check_frame("f4444", {7'h19, 7'h19, 7'h19, 7'h19}, 4'b1111);

      // Reset in the middle of digit 2 with a load pending.
      do_load(16'h5555, 4'b0000, 4'b0000);
      repeat (19) tick();
      check_val("pre_rst_an", 32'(an_o), 32'hB);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("midrst_an", 32'(an_o), 32'hF);
      check_val("midrst_seg", 32'(seg_o), 32'h7F);
      check_val("midrst_busy", 32'(busy_o), 32'd0);
      check_val("midrst_frame", 32'(frame_o), 32'd0);
      dark_ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if ((an_o !== 4'hF) || (seg_o !== 7'h7F) || (busy_o !== 1'b0)) dark_ok = 1'b0;
      end
      check_val("dark_after_rst", 32'(dark_ok), 32'd1);

      wait_frame("frame_post_rst");
      do_load(16'h0040, 4'b1111, 4'b0000);
      wait_frame("frame_0040");
`ifdef LEADING_ZERO_BLANK_EN
      check_frame("f0040", {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'b1100);
`else
      check_frame("f0040", {7'h40, 7'h40, 7'h19, 7'h40}, 4'b0000);
`endif
      do_load(16'h0000, 4'b0000, 4'b0000);
      wait_frame("frame_0000");
`ifdef LEADING_ZERO_BLANK_EN
      check_frame("f0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
`else
      check_frame("f0000", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
